// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants for the seven-segment scan controller: active-low hex patterns,
// blank/off codes, digit counts and the blink phase encoding.
package seg_scan_ctrl_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int LIT_DIGITS = 6;

    localparam logic [7:0] SEG_BLANK  = 8'hFF;
    localparam logic [7:0] SEG_EN_OFF = 8'hFF;

    // {dp,g,f,e,d,c,b,a}, active-low; dp is always off
    localparam logic [7:0] SEG_HEX_0 = 8'hC0;
    localparam logic [7:0] SEG_HEX_1 = 8'hF9;
    localparam logic [7:0] SEG_HEX_2 = 8'hA4;
    localparam logic [7:0] SEG_HEX_3 = 8'hB0;
    localparam logic [7:0] SEG_HEX_4 = 8'h99;
    localparam logic [7:0] SEG_HEX_5 = 8'h92;
    localparam logic [7:0] SEG_HEX_6 = 8'h82;
    localparam logic [7:0] SEG_HEX_7 = 8'hF8;
    localparam logic [7:0] SEG_HEX_8 = 8'h80;
    localparam logic [7:0] SEG_HEX_9 = 8'h90;
    localparam logic [7:0] SEG_HEX_A = 8'h88;
    localparam logic [7:0] SEG_HEX_B = 8'h83;
    localparam logic [7:0] SEG_HEX_C = 8'hC6;
    localparam logic [7:0] SEG_HEX_D = 8'hA1;
    localparam logic [7:0] SEG_HEX_E = 8'h86;
    localparam logic [7:0] SEG_HEX_F = 8'h8E;

    typedef enum logic {
        BLINK_OFF = 1'b0,
        BLINK_ON  = 1'b1
    } blink_state_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_hex_decode
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (nibble_i)
            4'h0: seg_o = SEG_HEX_0;
            4'h1: seg_o = SEG_HEX_1;
            4'h2: seg_o = SEG_HEX_2;
            4'h3: seg_o = SEG_HEX_3;
            4'h4: seg_o = SEG_HEX_4;
            4'h5: seg_o = SEG_HEX_5;
            4'h6: seg_o = SEG_HEX_6;
            4'h7: seg_o = SEG_HEX_7;
            4'h8: seg_o = SEG_HEX_8;
            4'h9: seg_o = SEG_HEX_9;
            4'hA: seg_o = SEG_HEX_A;
            4'hB: seg_o = SEG_HEX_B;
            4'hC: seg_o = SEG_HEX_C;
            4'hD: seg_o = SEG_HEX_D;
            4'hE: seg_o = SEG_HEX_E;
            4'hF: seg_o = SEG_HEX_F;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 8-digit multiplexed seven-segment and LED driver with frame-latched digit data,
// leading-zero blanking and synchronous blinking. All outputs are registered.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 25000000,
    parameter bit LZB       = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [23:0] data_display,
    input  logic [23:0] led_display,
    input  logic        blink_need,
    output logic [7:0]  seg_en,
    output logic [7:0]  seg_out,
    output logic [23:0] led_out
);

    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);
    localparam int DIGIT_W = $clog2(NUM_DIGITS);

    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [DIGIT_W-1:0] digit_idx_q, digit_idx_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    blink_state_t       blink_state_q, blink_state_d;
    logic [23:0]        shadow_q, shadow_d;
    logic               load_q;
    logic [7:0]         seg_en_q, seg_en_d;
    logic [7:0]         seg_out_q, seg_out_d;
    logic [23:0]        led_out_q, led_out_d;

    logic               scan_tc;
    logic               blink_tc;
    logic               blink_dark;
    logic [3:0]         nibble;
    logic [7:0]         dec_seg;
    logic               blanked;

    seg7_hex_decode u_decode (
        .nibble_i (nibble),
        .seg_o    (dec_seg)
    );

    // Scan counters and frame latch; load_q grabs the first frame right after reset
    always_comb begin
        scan_tc     = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
        scan_cnt_d  = scan_tc ? '0 : scan_cnt_q + SCAN_W'(1);
        digit_idx_d = scan_tc ? digit_idx_q + DIGIT_W'(1) : digit_idx_q;
        shadow_d    = shadow_q;
        if (load_q || (scan_tc && digit_idx_q == DIGIT_W'(NUM_DIGITS - 1))) begin
            shadow_d = data_display;
        end
        blink_tc    = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));
        blink_cnt_d = blink_tc ? '0 : blink_cnt_q + BLINK_W'(1);
    end

    // Blink phase FSM: held visible while no blink is requested
    always_comb begin
        blink_state_d = blink_state_q;
        if (!blink_need) begin
            blink_state_d = BLINK_ON;
        end else if (blink_tc) begin
            blink_state_d = (blink_state_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
        end
    end

    always_comb begin
        nibble = 4'h0;
        case (digit_idx_q)
            3'd0:    nibble = shadow_q[3:0];
            3'd1:    nibble = shadow_q[7:4];
            3'd2:    nibble = shadow_q[11:8];
            3'd3:    nibble = shadow_q[15:12];
            3'd4:    nibble = shadow_q[19:16];
            3'd5:    nibble = shadow_q[23:20];
            default: nibble = 4'h0;
        endcase
    end

    // A digit is a leading zero when it and every higher shown nibble are zero
    always_comb begin
        blanked    = LZB && (digit_idx_q != '0) && ((shadow_q >> {digit_idx_q, 2'b00}) == 24'h0);
        blink_dark = blink_need && (blink_state_q == BLINK_OFF);
        seg_en_d   = SEG_EN_OFF;
        seg_out_d  = SEG_BLANK;
        led_out_d  = blink_dark ? 24'h0 : led_display;
        if (!blink_dark && !blanked && (digit_idx_q < DIGIT_W'(LIT_DIGITS))) begin
            seg_en_d  = ~(8'h01 << digit_idx_q);
            seg_out_d = dec_seg;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            scan_cnt_q    <= '0;
            digit_idx_q   <= '0;
            blink_cnt_q   <= '0;
            blink_state_q <= BLINK_ON;
            shadow_q      <= 24'h0;
            load_q        <= 1'b1;
            seg_en_q      <= SEG_EN_OFF;
            seg_out_q     <= SEG_BLANK;
            led_out_q     <= 24'h0;
        end else begin
            scan_cnt_q    <= scan_cnt_d;
            digit_idx_q   <= digit_idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_state_q <= blink_state_d;
            shadow_q      <= shadow_d;
            load_q        <= 1'b0;
            seg_en_q      <= seg_en_d;
            seg_out_q     <= seg_out_d;
            led_out_q     <= led_out_d;
        end
    end

    assign seg_en  = seg_en_q;
    assign seg_out = seg_out_q;
    assign led_out = led_out_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with SCAN_DIV=4, BLINK_DIV=64: frame table plus
// hand-written sequences for mid-frame data change, blinking and reset mid-scan.
module tb_seg_scan_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [23:0] data_display;
    logic [23:0] led_display;
    logic        blink_need;
    logic [7:0]  seg_en;
    logic [7:0]  seg_out;
    logic [23:0] led_out;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    typedef struct {
        logic [23:0]     data;
        logic [5:0][7:0] en;
        logic [5:0][7:0] seg;
    } frame_vec_t;

    frame_vec_t vecs[6];
    frame_vec_t v_two;

    always #5 clock = ~clock;

    seg_scan_ctrl #(
        .SCAN_DIV  (4),
        .BLINK_DIV (64),
        .LZB       (1'b1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .data_display (data_display),
        .led_display  (led_display),
        .blink_need   (blink_need),
        .seg_en       (seg_en),
        .seg_out      (seg_out),
        .led_out      (led_out)
    );

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Step until the edge that latches a new frame has just passed
    task automatic align_frame();
        do tick(); while (cyc % 32 != 0);
    endtask

    task automatic check_frame(input frame_vec_t v, input string tag);
        for (int s = 0; s < 32; s++) begin
            tick();
            if (s % 4 == 2) begin
                int d;
                d = s / 4;
                if (d < 6) begin
                    chk($sformatf("%s_en%0d", tag, d), {16'h0, seg_en}, {16'h0, v.en[d]});
                    chk($sformatf("%s_seg%0d", tag, d), {16'h0, seg_out}, {16'h0, v.seg[d]});
                end else begin
                    chk($sformatf("%s_en%0d", tag, d), {16'h0, seg_en}, 24'hFF);
                    chk($sformatf("%s_seg%0d", tag, d), {16'h0, seg_out}, 24'hFF);
                end
            end
        end
    endtask

    initial begin
        vecs[0] = '{24'h123456, 48'hDFEFF7FBFDFE, 48'hF9A4B0999282};
        vecs[1] = '{24'h00000A, 48'hFFFFFFFFFFFE, 48'hFFFFFFFFFF88};
        vecs[2] = '{24'h000000, 48'hFFFFFFFFFFFE, 48'hFFFFFFFFFFC0};
        vecs[3] = '{24'h0F00B0, 48'hFFEFF7FBFDFE, 48'hFF8EC0C083C0};
        vecs[4] = '{24'h789CDE, 48'hDFEFF7FBFDFE, 48'hF88090C6A186};
        vecs[5] = '{24'h000100, 48'hFFFFFFFBFDFE, 48'hFFFFFFF9C0C0};
        v_two   = '{24'h222222, 48'hDFEFF7FBFDFE, 48'hA4A4A4A4A4A4};

        // Reset held three cycles
        reset        = 1'b1;
        data_display = 24'h123456;
        led_display  = 24'h5A5A5A;
        blink_need   = 1'b0;
        tick(); tick(); tick();
        chk("rst_en", {16'h0, seg_en}, 24'hFF);
        chk("rst_seg", {16'h0, seg_out}, 24'hFF);
        chk("rst_led", led_out, 24'h0);

        reset = 1'b0;
        cyc   = 0;
        tick();
        chk("first_en", {16'h0, seg_en}, 24'hFE);
        chk("first_seg", {16'h0, seg_out}, 24'hC0);
        chk("first_led", led_out, 24'h5A5A5A);
        led_display = 24'h123123;
        tick();
        chk("led_follow", led_out, 24'h123123);
        tick();
        chk("first_frame_d0", {16'h0, seg_out}, 24'h82);

        // Frame table
        for (int i = 0; i < 6; i++) begin
            data_display = vecs[i].data;
            align_frame();
            check_frame(vecs[i], $sformatf("v%0d", i));
        end

        // Data changes while digit 3 is being scanned
        data_display = 24'h111111;
        align_frame();
        for (int s = 0; s < 32; s++) begin
            tick();
            if (s % 4 == 2 && s / 4 < 6) begin
                chk($sformatf("tear_seg%0d", s / 4), {16'h0, seg_out}, 24'hF9);
            end
            if (s == 12) data_display = 24'h222222;
        end
        check_frame(v_two, "next");

        // Blinking
        while (cyc % 64 != 0) tick();
        led_display = 24'hABCDEF;
        blink_need  = 1'b1;
        for (int s = 1; s <= 200; s++) begin
            logic on;
            tick();
            on = (((s - 1) / 64) % 2) == 0;
            chk($sformatf("blink_led_%0d", s), led_out, on ? 24'hABCDEF : 24'h0);
            if (!on) begin
                chk($sformatf("blink_en_%0d", s), {16'h0, seg_en}, 24'hFF);
                chk($sformatf("blink_seg_%0d", s), {16'h0, seg_out}, 24'hFF);
            end
            if (s == 1) chk("blink_on_d0", {16'h0, seg_en}, 24'hFE);
        end
        blink_need = 1'b0;
        tick();
        chk("unblink_led", led_out, 24'hABCDEF);

        // Reset while digit 4 is scanned and the blink phase is dark
        while (cyc % 64 != 0) tick();
        data_display = 24'h123456;
        blink_need   = 1'b1;
        for (int s = 0; s < 80; s++) tick();
        chk("pre_rst_dark", led_out, 24'h0);
        reset = 1'b1;
        tick();
        chk("mid_rst_en", {16'h0, seg_en}, 24'hFF);
        chk("mid_rst_seg", {16'h0, seg_out}, 24'hFF);
        chk("mid_rst_led", led_out, 24'h0);
        reset = 1'b0;
        cyc   = 0;
        tick();
        chk("restart_en", {16'h0, seg_en}, 24'hFE);
        chk("restart_seg", {16'h0, seg_out}, 24'hC0);
        chk("restart_led", led_out, 24'hABCDEF);
        while (cyc < 5) tick();
        chk("restart_d1_en", {16'h0, seg_en}, 24'hFD);
        chk("restart_d1_seg", {16'h0, seg_out}, 24'h92);
        while (cyc < 64) tick();
        chk("restart_vis_end", led_out, 24'hABCDEF);
        tick();
        chk("restart_dark", led_out, 24'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
